ysyx_25060170_idu_issue: RTL and testbench

Parametrised decode/issue stage sitting between the fetch stage and EX, the successor of the combinational ID stage. It decodes register usage, resolves operands through an N-source forwarding network with a generalised load-use interlock (any forward source may flag its data as not yet available), and registers the result into an ID/EX pipeline register under a valid/ready handshake with flush. It also keeps a saturating interlock-stall counter for performance analysis.

---
 rtl/ysyx_25060170_idu_issue.sv | 131 +++++++++++++
 tb/tb_ysyx_25060170_idu_issue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_idu_issue.sv
// Decode/issue stage: register-usage decode, N-source operand forwarding with a
// pending-data interlock, and the ID/EX pipeline register with valid/ready and flush.
module ysyx_25060170_idu_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NFWD  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_addr,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_pending,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_inst,
  output logic [4:0]           out_rd,
  output logic                 out_rd_ena,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic            rs1_used, rs2_used, rd_ena;
  logic [4:0]      rd;
  logic [XLEN-1:0] op1, op2;
  logic            pend1, pend2;
  logic            hazard, fire;

  assign opcode = in_inst[6:0];

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_ena   = 1'b1;
    case (opcode)
      OPC_OP:                 begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OP_IMM, OPC_LOAD,
      OPC_JALR:               rs1_used = 1'b1;
      OPC_STORE, OPC_BRANCH:  begin rs1_used = 1'b1; rs2_used = 1'b1; rd_ena = 1'b0; end
      default:                ;
    endcase
    if (in_inst[11:7] == 5'd0) rd_ena = 1'b0;
  end

  assign rs1_addr = rs1_used ? in_inst[19:15] : 5'd0;
  assign rs2_addr = rs2_used ? in_inst[24:20] : 5'd0;
  assign rd       = rd_ena ? in_inst[11:7] : 5'd0;

  // Walk oldest to youngest so the youngest matching source is applied last and wins.
  always_comb begin
    op1   = rs1_data;
    op2   = rs2_data;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int unsigned k = 0; k < NFWD; k++) begin
      if (fwd_valid[NFWD-1-k] && fwd_addr[5*(NFWD-1-k) +: 5] == rs1_addr) begin
        op1   = fwd_data[XLEN*(NFWD-1-k) +: XLEN];
        pend1 = fwd_pending[NFWD-1-k];
      end
      if (fwd_valid[NFWD-1-k] && fwd_addr[5*(NFWD-1-k) +: 5] == rs2_addr) begin
        op2   = fwd_data[XLEN*(NFWD-1-k) +: XLEN];
        pend2 = fwd_pending[NFWD-1-k];
      end
    end
    // Unused operands carry address 0, so this also covers the unused case.
    if (rs1_addr == 5'd0) begin
      op1   = '0;
      pend1 = 1'b0;
    end
    if (rs2_addr == 5'd0) begin
      op2   = '0;
      pend2 = 1'b0;
    end
  end

  assign hazard   = in_valid && (pend1 || pend2);
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign fire     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_rd     <= '0;
      out_rd_ena <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= fire;
      if (fire) begin
        out_op1    <= op1;
        out_op2    <= op2;
        out_pc     <= in_pc;
        out_inst   <= in_inst;
        out_rd     <= rd;
        out_rd_ena <= rd_ena;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_idu_issue.sv
// Directed bench for the decode/issue stage; counter built 2 bits wide so saturation is reachable.
module tb_ysyx_25060170_idu_issue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NFWD  = 3;
  localparam int unsigned CNT_W = 2;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [XLEN-1:0]      in_pc;
  logic                 flush;
  logic [4:0]           rs1_addr, rs2_addr;
  logic [XLEN-1:0]      rs1_data, rs2_data;
  logic [NFWD-1:0]      fwd_valid;
  logic [5*NFWD-1:0]    fwd_addr;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_pending;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_op1, out_op2, out_pc;
  logic [31:0]          out_inst;
  logic [4:0]           out_rd;
  logic                 out_rd_ena;
  logic [CNT_W-1:0]     stall_cnt;

  logic [XLEN-1:0] rf [32];
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_valid;

  ysyx_25060170_idu_issue #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(out_rd), .out_rd_ena(out_rd_ena), .stall_cnt(stall_cnt)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] r1,
                                        input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic set_fwd(input int unsigned i, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic p);
    fwd_valid[i]           = v;
    fwd_addr[5*i +: 5]     = a;
    fwd_data[XLEN*i +: XLEN] = d;
    fwd_pending[i]         = p;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_valid  = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[1] = 5;
    rf[2] = 7;
    in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 1;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0; fwd_pending = '0;
    rst = 1;
    #2 rst = 0;
    #10;
    check("rst_valid", out_valid, 0);
    check("rst_op1", out_op1, 0);
    check("rst_op2", out_op2, 0);
    check("rst_pc", out_pc, 0);
    check("rst_inst", out_inst, 0);
    check("rst_rd", out_rd, 0);
    check("rst_rd_ena", out_rd_ena, 0);
    check("rst_cnt", stall_cnt, 0);
    #1 rst = 1;
    tick();

    // add x3,x1,x2
    in_valid = 1; in_inst = rtype(3, 1, 2); in_pc = 32'h100;
    #1;
    check("add_ready", in_ready, 1);
    check("add_rs1a", rs1_addr, 1);
    check("add_rs2a", rs2_addr, 2);
    tick();
    check("add_valid", out_valid, 1);
    check("add_op1", out_op1, 5);
    check("add_op2", out_op2, 7);
    check("add_rd", out_rd, 3);
    check("add_rd_ena", out_rd_ena, 1);
    check("add_pc", out_pc, 32'h100);
    check("add_inst", out_inst, 32'h002081B3);

    for (int k = 0; k < 10; k++) begin
      in_inst = rtype(5'(k + 1), 1, 2);
      in_pc   = 32'h200 + 32'(4 * k);
      tick();
      if (out_valid) n_valid++;
      check("b2b_pc", out_pc, 32'h200 + 32'(4 * k));
      check("b2b_rd", out_rd, 5'(k + 1));
    end
    check("b2b_count", n_valid, 10);

    // forward priority on x1: add x4,x1,x0
    rf[1] = 32'h11;
    in_inst = rtype(4, 1, 0); in_pc = 32'h240;
    set_fwd(0, 1, 1, 32'hAA, 0);
    set_fwd(1, 1, 9, 32'hBB, 0);
    set_fwd(2, 1, 1, 32'hCC, 0);
    tick();
    check("fwd_src0", out_op1, 32'hAA);
    check("fwd_x0_op2", out_op2, 0);
    fwd_valid[0] = 0;
    tick();
    check("fwd_src2", out_op1, 32'hCC);
    fwd_valid = '0;
    tick();
    check("fwd_rf", out_op1, 32'h11);
    fwd_valid = 3'b101; fwd_pending = 3'b100;
    #1;
    check("hidden_pend_ready", in_ready, 1);
    tick();
    check("hidden_pend_op1", out_op1, 32'hAA);
    fwd_valid = '0; fwd_pending = '0;

    // load-use: add x6,x5,x0 with pending source 0
    in_inst = rtype(6, 5, 0); in_pc = 32'h300;
    set_fwd(0, 1, 5, 32'h0, 1);
    #1;
    check("lu_ready0", in_ready, 0);
    tick();
    check("lu_bubble1", out_valid, 0);
    check("lu_cnt1", stall_cnt, 1);
    check("lu_ready1", in_ready, 0);
    tick();
    check("lu_bubble2", out_valid, 0);
    check("lu_cnt2", stall_cnt, 2);
    set_fwd(0, 1, 5, 32'h1234, 0);
    #1;
    check("lu_ready_clear", in_ready, 1);
    tick();
    check("lu_valid", out_valid, 1);
    check("lu_op1", out_op1, 32'h1234);
    check("lu_rd", out_rd, 6);
    check("lu_cnt_hold", stall_cnt, 2);
    fwd_valid = '0;

    // lui x0,1
    in_inst = {20'h00001, 5'd0, 7'b0110111}; in_pc = 32'h304;
    tick();
    check("lui_valid", out_valid, 1);
    check("lui_rd_ena", out_rd_ena, 0);
    check("lui_rd", out_rd, 0);

    // addi x1,x0,3 with a pending source aimed at x0
    set_fwd(0, 1, 0, 32'hDEAD, 1);
    in_inst = {12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011}; in_pc = 32'h308;
    #1;
    check("x0_pend_ready", in_ready, 1);
    tick();
    check("x0_valid", out_valid, 1);
    check("x0_op1", out_op1, 0);
    check("x0_rd", out_rd, 1);
    check("x0_cnt", stall_cnt, 2);
    fwd_valid = '0; fwd_pending = '0;

    // sw x2,0(x1)
    in_inst = {7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011}; in_pc = 32'h30C;
    #1;
    check("sw_rs2a", rs2_addr, 2);
    check("sw_rs1a", rs1_addr, 1);
    tick();
    check("sw_rd_ena", out_rd_ena, 0);
    check("sw_rd", out_rd, 0);
    check("sw_op1", out_op1, 32'h11);
    check("sw_op2", out_op2, 7);

    // backpressure then flush
    in_inst = rtype(3, 1, 2); in_pc = 32'h400;
    tick();
    check("bp_load", out_pc, 32'h400);
    out_ready = 0;
    in_inst = rtype(7, 1, 2); in_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_pc", out_pc, 32'h400);
      check("bp_rd", out_rd, 3);
    end
    flush = 1; in_pc = 32'h408;
    #1;
    check("fl_ready", in_ready, 1);
    tick();
    check("fl_valid", out_valid, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("fl_dropped", out_valid, 0);

    // saturation with a 2-bit counter, then reset mid-stall
    in_valid = 1; in_inst = rtype(6, 5, 0); in_pc = 32'h500;
    set_fwd(0, 1, 5, 32'h0, 1);
    tick();
    check("sat_cnt3", stall_cnt, 3);
    for (int k = 0; k < 4; k++) tick();
    check("sat_cnt_hold", stall_cnt, 3);
    check("sat_valid", out_valid, 0);
    #2 rst = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_pc", out_pc, 0);
    check("mid_rst_inst", out_inst, 0);
    check("mid_rst_rd", out_rd, 0);
    check("mid_rst_op1", out_op1, 0);
    check("mid_rst_op2", out_op2, 0);
    check("mid_rst_rd_ena", out_rd_ena, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_rs1a", rs1_addr, 5);
    #3 rst = 1;
    in_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
